// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
// Optional signed status flags V/N/Z are generated when CLA_ADDER_FLAGS_EN is defined.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             G_prime,
    output logic             P_prime,
    output logic             V,
    output logic             N,
    output logic             Z
);
    localparam int SW   = WIDTH / STAGES;
    localparam int GPS  = SW / GROUP;
    localparam int LAST = STAGES - 1;

    logic [WIDTH-1:0] x_q [STAGES];
    logic [WIDTH-1:0] y_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             g_q [STAGES];
    logic             p_q [STAGES];
    logic             vld_q [STAGES];

    logic [WIDTH-1:0] x_n [STAGES];
    logic [WIDTH-1:0] y_n [STAGES];
    logic [WIDTH-1:0] s_n [STAGES];
    logic             c_n [STAGES];
    logic             g_n [STAGES];
    logic             p_n [STAGES];
    logic             vld_n [STAGES];

    logic [WIDTH-1:0] xi, yi, si;
    logic             ci, gi, pi;
    logic             gen, prop, gg, gp, c_grp, gs, ps;
    logic             advance;

    assign advance  = ~vld_q[LAST] | out_ready;
    assign in_ready = advance;

    // Stage k adds slice k using the carry and partial G/P handed over by stage k-1.
    always_comb begin
        xi = '0; yi = '0; si = '0; ci = 1'b0; gi = 1'b0; pi = 1'b1;
        gen = 1'b0; prop = 1'b0; gg = 1'b0; gp = 1'b1; c_grp = 1'b0; gs = 1'b0; ps = 1'b1;
        for (int k = 0; k < STAGES; k++) begin
            x_n[k] = '0; y_n[k] = '0; s_n[k] = '0;
            c_n[k] = 1'b0; g_n[k] = 1'b0; p_n[k] = 1'b0; vld_n[k] = 1'b0;
        end
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                xi = A;
                yi = sub ? ~B : B;
                ci = sub | Cin;
                si = '0;
                gi = 1'b0;
                pi = 1'b1;
                vld_n[k] = in_valid;
            end else begin
                xi = x_q[k-1];
                yi = y_q[k-1];
                ci = c_q[k-1];
                si = s_q[k-1];
                gi = g_q[k-1];
                pi = p_q[k-1];
                vld_n[k] = vld_q[k-1];
            end
            c_grp = ci;
            gs    = 1'b0;
            ps    = 1'b1;
            for (int j = 0; j < GPS; j++) begin
                gg = 1'b0;
                gp = 1'b1;
                // gg/gp are the prefix generate/propagate of the group below bit b
                for (int b = 0; b < GROUP; b++) begin
                    gen  = xi[k*SW + j*GROUP + b] & yi[k*SW + j*GROUP + b];
                    prop = xi[k*SW + j*GROUP + b] ^ yi[k*SW + j*GROUP + b];
                    si[k*SW + j*GROUP + b] = prop ^ (gg | (gp & c_grp));
                    gg = gen | (prop & gg);
                    gp = gp & prop;
                end
                c_grp = gg | (gp & c_grp);
                gs    = gg | (gp & gs);
                ps    = ps & gp;
            end
            x_n[k] = xi;
            y_n[k] = yi;
            s_n[k] = si;
            c_n[k] = c_grp;
            g_n[k] = gs | (ps & gi);
            p_n[k] = pi & ps;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= '0; y_q[k] <= '0; s_q[k] <= '0;
                c_q[k] <= 1'b0; g_q[k] <= 1'b0; p_q[k] <= 1'b0; vld_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= x_n[k]; y_q[k] <= y_n[k]; s_q[k] <= s_n[k];
                c_q[k] <= c_n[k]; g_q[k] <= g_n[k]; p_q[k] <= p_n[k]; vld_q[k] <= vld_n[k];
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign S         = s_q[LAST];
    assign C_out     = c_q[LAST];
    assign G_prime   = g_q[LAST];
    assign P_prime   = p_q[LAST];

`ifdef CLA_ADDER_FLAGS_EN
    logic v_n, v_q, n_q, z_q;

    assign v_n = (x_n[LAST][WIDTH-1] == y_n[LAST][WIDTH-1]) &
                 (s_n[LAST][WIDTH-1] != x_n[LAST][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= 1'b0; n_q <= 1'b0; z_q <= 1'b0;
        end else if (advance) begin
            v_q <= v_n;
            n_q <= s_n[LAST][WIDTH-1];
            z_q <= (s_n[LAST] == '0);
        end
    end

    assign V = v_q;
    assign N = n_q;
    assign Z = z_q;
`else
    assign V = 1'b0;
    assign N = 1'b0;
    assign Z = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - directed-vector bench for pipelined_cla_adder (32/4/2 and 16/4/4)
module tb_pipelined_cla_adder;
`ifdef CLA_ADDER_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        iv0, ir0, cin0, sub0, ov0, or0, c0, g0, p0, v0, n0, z0;
    logic [31:0] a0, b0, s0;
    logic        iv1, ir1, cin1, sub1, ov1, or1, c1, g1, p1, v1, n1, z1;
    logic [15:0] a1, b1, s1;

    int errors = 0;
    int checks = 0;

    pipelined_cla_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
        .Cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .S(s0), .C_out(c0),
        .G_prime(g0), .P_prime(p0), .V(v0), .N(n0), .Z(z0)
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .STAGES(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .Cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .S(s1), .C_out(c1),
        .G_prime(g1), .P_prime(p1), .V(v1), .N(n1), .Z(z1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input string t, input logic [31:0] a, input logic [31:0] b, input logic cn,
                         input logic sb, input logic [31:0] es, input logic ec, input logic eg,
                         input logic ep, input logic ev, input logic en, input logic ez);
        int lat;
        a0 = a; b0 = b; cin0 = cn; sub0 = sb; iv0 = 1'b1; or0 = 1'b1;
        #1;
        check({t, "_in_ready"}, 32'(ir0), 32'd1);
        step();
        iv0 = 1'b0;
        lat = 1;
        while (!ov0 && lat < 10) begin
            step();
            lat++;
        end
        check({t, "_latency"}, 32'(lat), 32'd2);
        check({t, "_S"}, s0, es);
        check({t, "_C_out"}, 32'(c0), 32'(ec));
        check({t, "_G_prime"}, 32'(g0), 32'(eg));
        check({t, "_P_prime"}, 32'(p0), 32'(ep));
        check({t, "_V"}, 32'(v0), 32'(FL & ev));
        check({t, "_N"}, 32'(n0), 32'(FL & en));
        check({t, "_Z"}, 32'(z0), 32'(FL & ez));
    endtask

    task automatic run16(input int i, input logic [15:0] a, input logic [15:0] b, input logic cn,
                         input logic sb);
        logic [15:0] x, y;
        logic [16:0] sum, gsum;
        logic        c_0;
        int          lat;
        x    = a;
        y    = sb ? ~b : b;
        c_0  = sb ? 1'b1 : cn;
        sum  = {1'b0, x} + {1'b0, y} + {16'd0, c_0};
        gsum = {1'b0, x} + {1'b0, y};
        a1 = a; b1 = b; cin1 = cn; sub1 = sb; iv1 = 1'b1; or1 = 1'b1;
        step();
        iv1 = 1'b0;
        lat = 1;
        while (!ov1 && lat < 12) begin
            step();
            lat++;
        end
        check($sformatf("w16_%0d_latency", i), 32'(lat), 32'd4);
        check($sformatf("w16_%0d_S", i), 32'(s1), 32'(sum[15:0]));
        check($sformatf("w16_%0d_C_out", i), 32'(c1), 32'(sum[16]));
        check($sformatf("w16_%0d_G_prime", i), 32'(g1), 32'(gsum[16]));
        check($sformatf("w16_%0d_P_prime", i), 32'(p1), 32'(&(x ^ y)));
        check($sformatf("w16_%0d_V", i), 32'(v1),
              32'(FL & (x[15] == y[15]) & (sum[15] != x[15])));
        check($sformatf("w16_%0d_N", i), 32'(n1), 32'(FL & sum[15]));
        check($sformatf("w16_%0d_Z", i), 32'(z1), 32'(FL & (sum[15:0] == 16'd0)));
    endtask

    initial begin
        int prod, cons, stall_left, any_ov;
        logic stalled_once, in_x;
        logic [31:0] held;

        reset = 1'b1;
        iv0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; or1 = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check("rst_out_valid", 32'(ov0), 32'd0);
        check("rst_S", s0, 32'd0);
        check("rst_C_out", 32'(c0), 32'd0);
        check("rst_GP", 32'({g0, p0}), 32'd0);
        check("rst_in_ready", 32'(ir0), 32'd1);
        check("rst_w16_out_valid", 32'(ov1), 32'd0);

        run32("add_alt", 32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run32("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run32("add_ovf", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run32("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run32("sub_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) step();

        // back-pressure: four adds of (i+1)+(i+1), 3-cycle stall on the first result
        prod = 0; cons = 0; stall_left = 3; stalled_once = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && cons < 4; cyc++) begin
            iv0 = (prod < 4); a0 = 32'(prod + 1); b0 = 32'(prod + 1); cin0 = 1'b0; sub0 = 1'b0;
            or0 = !(ov0 && !stalled_once);
            #1;
            if (!or0) begin
                check("bp_in_ready_stalled", 32'(ir0), 32'd0);
                if (stall_left == 3) held = s0;
                else check("bp_S_held", s0, held);
                stall_left--;
                if (stall_left == 0) stalled_once = 1'b1;
            end
            in_x = iv0 & ir0;
            if (ov0 && or0) begin
                check($sformatf("bp_result_%0d", cons), s0, 32'(2 * (cons + 1)));
                cons++;
            end
            step();
            if (in_x) prod++;
        end
        check("bp_count", 32'(cons), 32'd4);
        check("bp_stalled", 32'(stalled_once), 32'd1);
        iv0 = 1'b0; or0 = 1'b1;
        any_ov = 0;
        repeat (4) begin
            step();
            if (ov0) any_ov++;
        end
        check("bp_no_duplicate", 32'(any_ov), 32'd0);

        // reset with two operations in flight
        a0 = 32'd3; b0 = 32'd4; iv0 = 1'b1;
        step();
        a0 = 32'd10; b0 = 32'd20;
        step();
        iv0 = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_out_valid", 32'(ov0), 32'd0);
        check("mid_rst_S", s0, 32'd0);
        check("mid_rst_flags", 32'({c0, g0, p0, v0, n0, z0}), 32'd0);
        check("mid_rst_in_ready", 32'(ir0), 32'd1);
        any_ov = 0;
        repeat (5) begin
            step();
            if (ov0) any_ov++;
        end
        check("mid_rst_no_stale", 32'(any_ov), 32'd0);

        run16(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run16(1, 16'h8000, 16'h0001, 1'b0, 1'b1);
        for (int i = 2; i < 10; i++)
            run16(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'(i % 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
